// File: rtl/ram_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_reader_pkg
// Description : Shared constants for the RAM burst reader: FSM state
//               encoding, read-buffer depth and the issue-credit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_burst_reader_pkg;

    // Words the read buffer can hold; also the issue credit limit.
    localparam int BUF_DEPTH = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A new read may issue only if every word already buffered or in flight,
    // minus the word leaving this cycle, still leaves a free buffer slot.
    function automatic logic credit_ok(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] occupancy;
        occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occupancy < 3'(BUF_DEPTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_read_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ram_read_skid_buffer
// Description : 2-entry FIFO with a registered head. Push and pop in the same
//               cycle are allowed; pushing into a full buffer without a pop
//               is an error condition.
// Ports       : clk, rst_n      - clock, async active-low reset
//               push_i, din_i   - write strobe and word
//               pop_i           - consumer takes the head word
//               count_o         - words currently held (0..2)
//               valid_o, head_o - head entry
// Revision    : 1.0 - initial release
// ============================================================================
module ram_read_skid_buffer
    import ram_burst_reader_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             w_pop;

    // A pop against an empty buffer is ignored.
    assign w_pop = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            if (push_i && w_pop) begin
                // Occupancy unchanged; the incoming word lands behind
                // whatever remains after the head leaves.
                if (count_q == 2'd2) begin
                    head_q <= tail_q;
                    tail_q <= din_i;
                end else begin
                    head_q <= din_i;
                end
            end else if (push_i) begin
                if (count_q == 2'd0) begin
                    head_q <= din_i;
                end else begin
                    tail_q <= din_i;
                end
                count_q <= count_q + 2'd1;
            end else if (w_pop) begin
                head_q  <= tail_q;
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign head_o  = head_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !w_pop && (count_q == 2'(BUF_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_reader
// Description : Burst read master for a registered-address dual-port RAM.
//               Takes {addr, len} commands, issues reads under a 2-word
//               credit, absorbs the one-cycle RAM latency through a 2-entry
//               buffer and streams words out on valid/ready with a last flag.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               cmd_valid_i/cmd_ready_o         - command handshake
//               cmd_addr_i, cmd_len_i           - burst start address, length
//               read_address_o, read_enable_o   - RAM read port
//               ram_data_i                      - RAM data_out
//               out_valid_o/out_ready_i         - output stream handshake
//               out_data_o, out_last_o          - streamed word, final flag
//               busy_o, done_o                  - status, completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int LEN_WIDTH     = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]     cmd_len_i,
    output logic [ADDRESS_WIDTH-1:0] read_address_o,
    output logic                     read_enable_o,
    input  logic [DATA_WIDTH-1:0]    ram_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    logic [1:0]               state_q,     state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
    logic [LEN_WIDTH-1:0]     len_q,       len_d;
    logic [LEN_WIDTH-1:0]     remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]     cap_cnt_q,   cap_cnt_d;
    logic                     inflight_q;

    logic                     w_cmd_fire;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_last_tag;
    logic [1:0]               w_buf_count;
    logic                     w_buf_valid;
    logic [DATA_WIDTH:0]      w_buf_head;

    assign w_cmd_fire = cmd_valid_i && (state_q == ST_IDLE);
    assign w_pop      = w_buf_valid && out_ready_i;
    assign w_issue    = (state_q == ST_ISSUE) && (remaining_q != '0)
                        && credit_ok(w_buf_count, inflight_q, w_pop);

    // The word arriving now is ordinal cap_cnt_q+1; tag it if that is len.
    assign w_last_tag = ((cap_cnt_q + LEN_WIDTH'(1)) == len_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        cap_cnt_d   = inflight_q ? (cap_cnt_q + LEN_WIDTH'(1)) : cap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    addr_d      = cmd_addr_i;
                    len_d       = cmd_len_i;
                    remaining_d = cmd_len_i;
                    cap_cnt_d   = '0;
                    // A zero-length burst passes through DRAIN, which resolves
                    // at once, so done follows the handshake by two edges.
                    state_d     = (cmd_len_i == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_issue) begin
                    addr_d      = addr_q + ADDRESS_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((w_buf_count == 2'd0) && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            cap_cnt_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            cap_cnt_q   <= cap_cnt_d;
            inflight_q  <= w_issue;
        end
    end

    // RAM data is valid the cycle after an issue; capture it on the next edge.
    ram_read_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   ({w_last_tag, ram_data_i}),
        .pop_i   (w_pop),
        .count_o (w_buf_count),
        .valid_o (w_buf_valid),
        .head_o  (w_buf_head)
    );

    assign cmd_ready_o    = (state_q == ST_IDLE);
    assign read_address_o = addr_q;
    assign read_enable_o  = w_issue;
    assign out_valid_o    = w_buf_valid;
    assign out_data_o     = w_buf_head[DATA_WIDTH-1:0];
    assign out_last_o     = w_buf_valid && w_buf_head[DATA_WIDTH];
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_reader
// Description : Self-checking bench for ram_burst_reader. Models the RAM as a
//               registered-read array and predicts the output stream as
//               mem[(addr+i) mod 256] with last on the final word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic [7:0]  read_address;
    logic        read_enable;
    logic [15:0] ram_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    // Observations gathered by collect()
    logic [15:0] got_q [$];
    bit          last_q [$];
    int          pop_k [$];
    int          acc_k [$];
    int          done_k [$];
    logic [7:0]  rd_addr_q [$];
    int          first_valid_k;
    int          credit_viol;
    int          hold_viol;
    bit          timed_out;
    logic        fin_ready, fin_busy, fin_done;

    always #5 clk = ~clk;

    // RAM: registered read address, data valid the following cycle.
    always @(posedge clk) begin
        if (read_enable) ram_data <= mem[read_address];
    end

    ram_burst_reader #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (16),
        .LEN_WIDTH     (9)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_addr_i     (cmd_addr),
        .cmd_len_i      (cmd_len),
        .read_address_o (read_address),
        .read_enable_o  (read_enable),
        .ram_data_i     (ram_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_last_o     (out_last),
        .busy_o         (busy),
        .done_o         (done)
    );

    // Drives one or two commands (the second held valid until accepted) and
    // records the stream. Inputs change at negedge; sampling is 1ns later.
    // mode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random ready.
    task automatic collect(input logic [7:0] a1, input int l1, input bit two,
                           input logic [7:0] a2, input int l2, input int mode);
        logic [7:0]  ca [2];
        int          cl [2];
        int          ncmd, nacc, k, issued, popped, budget;
        bit          pop, prev_stall;
        logic [15:0] pd;
        logic        pl;
        ca[0] = a1; ca[1] = a2; cl[0] = l1; cl[1] = l2;
        ncmd = two ? 2 : 1;
        got_q.delete(); last_q.delete(); pop_k.delete(); acc_k.delete();
        done_k.delete(); rd_addr_q.delete();
        first_valid_k = -1; credit_viol = 0; hold_viol = 0; timed_out = 0;
        nacc = 0; k = 0; issued = 0; popped = 0; prev_stall = 0; pd = '0; pl = 1'b0;
        budget = 40 + 4 * (l1 + (two ? l2 : 0));
        while (done_k.size() < ncmd) begin
            @(negedge clk);
            if (nacc < ncmd) begin
                cmd_valid = 1'b1;
                cmd_addr  = ca[nacc];
                cmd_len   = 9'(cl[nacc]);
            end else begin
                cmd_valid = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            pop = out_valid && out_ready;
            if (cmd_valid && cmd_ready) begin
                acc_k.push_back(k);
                nacc++;
            end
            if (read_enable) begin
                if (issued - popped - int'(pop) >= 2) credit_viol++;
                rd_addr_q.push_back(read_address);
                issued++;
            end
            if (prev_stall && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
                hold_viol++;
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (pop) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
                pop_k.push_back(k);
                popped++;
            end
            if (done) done_k.push_back(k);
            k++;
            if (k > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        fin_ready = cmd_ready;
        fin_busy  = busy;
        fin_done  = done;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (cmd_ready !== 1'b1)     begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (read_enable !== 1'b0)   begin errors++; $display("FAIL reset_read_enable got %b want 0", read_enable); end
        checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        checks++; if (read_address !== 8'h00 || out_data !== 16'h0) begin errors++; $display("FAIL reset_addr_data got %h/%h want 00/0000", read_address, out_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_backpressure;
        collect(8'h10, 4, 0, 8'h00, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL nobp_timeout got timeout want completion"); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL nobp_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            logic [15:0] exp_w;
            exp_w = 16'h30 + 16'(3 * i);
            checks++; if (got_q[i] !== exp_w || last_q[i] !== (i == 3)) begin errors++; $display("FAIL nobp_word%0d got %h last %b want %h last %b", i, got_q[i], last_q[i], exp_w, (i == 3)); end
        end
        checks++; if (acc_k.size() != 1 || first_valid_k != acc_k[0] + 3) begin errors++; $display("FAIL nobp_latency got first_valid %0d want accept+3", first_valid_k); end
        checks++; if (pop_k.size() == 4 && pop_k[3] - pop_k[0] != 3) begin errors++; $display("FAIL nobp_consecutive got span %0d want 3", pop_k[3] - pop_k[0]); end
        checks++; if (done_k.size() != 1 || fin_done !== 1'b0) begin errors++; $display("FAIL nobp_done got %0d pulses, after=%b want 1,0", done_k.size(), fin_done); end
        checks++; if (fin_ready !== 1'b1 || fin_busy !== 1'b0) begin errors++; $display("FAIL nobp_idle got ready %b busy %b want 1 0", fin_ready, fin_busy); end
    endtask

    task automatic test_backpressure;
        collect(8'h00, 6, 0, 8'h00, 0, 1);
        checks++; if (timed_out || got_q.size() != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            checks++; if (got_q[i] !== mem[i] || last_q[i] !== (i == 5)) begin errors++; $display("FAIL bp_word%0d got %h last %b want %h last %b", i, got_q[i], last_q[i], mem[i], (i == 5)); end
        end
        checks++; if (credit_viol != 0) begin errors++; $display("FAIL bp_credit got %0d violations want 0", credit_viol); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d unstable stalls want 0", hold_viol); end
        checks++; if (rd_addr_q.size() != 6) begin errors++; $display("FAIL bp_issues got %0d want 6", rd_addr_q.size()); end
    endtask

    task automatic test_wrap;
        logic [7:0] ea;
        collect(8'hFE, 4, 0, 8'h00, 0, 2);
        checks++; if (timed_out || rd_addr_q.size() != 4 || got_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d issues %0d words want 4 4", rd_addr_q.size(), got_q.size()); end
        for (int i = 0; i < rd_addr_q.size() && i < got_q.size() && i < 4; i++) begin
            ea = 8'hFE + 8'(i);
            checks++; if (rd_addr_q[i] !== ea || got_q[i] !== mem[ea]) begin errors++; $display("FAIL wrap_%0d got addr %h data %h want %h %h", i, rd_addr_q[i], got_q[i], ea, mem[ea]); end
        end
        checks++; if (credit_viol != 0 || hold_viol != 0) begin errors++; $display("FAIL wrap_flow got credit %0d hold %0d want 0 0", credit_viol, hold_viol); end
    endtask

    task automatic test_zero_length;
        collect(8'h40, 0, 0, 8'h00, 0, 0);
        checks++; if (timed_out || rd_addr_q.size() != 0) begin errors++; $display("FAIL zero_reads got %0d want 0", rd_addr_q.size()); end
        checks++; if (first_valid_k != -1) begin errors++; $display("FAIL zero_valid got valid at %0d want none", first_valid_k); end
        checks++; if (done_k.size() != 1 || acc_k.size() != 1 || done_k[0] != acc_k[0] + 2) begin errors++; $display("FAIL zero_done got %0d pulses want 1 at accept+2", done_k.size()); end
        checks++; if (fin_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", fin_ready); end
    endtask

    task automatic test_back_to_back;
        collect(8'h80, 3, 1, 8'h90, 2, 0);
        checks++; if (timed_out || acc_k.size() != 2 || done_k.size() != 2) begin errors++; $display("FAIL b2b_counts got acc %0d done %0d want 2 2", acc_k.size(), done_k.size()); end
        checks++; if (acc_k.size() == 2 && done_k.size() >= 1 && acc_k[1] != done_k[0] + 1) begin errors++; $display("FAIL b2b_accept got %0d want %0d", acc_k[1], done_k[0] + 1); end
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL b2b_words got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            logic [7:0] ea;
            ea = (i < 3) ? 8'h80 + 8'(i) : 8'h90 + 8'(i - 3);
            checks++; if (got_q[i] !== mem[ea] || last_q[i] !== (i == 2 || i == 4)) begin errors++; $display("FAIL b2b_word%0d got %h last %b want %h", i, got_q[i], last_q[i], mem[ea]); end
        end
    endtask

    task automatic test_reset_mid_burst;
        int  pops, cyc;
        bit  saw_done;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 8'h50; cmd_len = 9'd8; out_ready = 1'b1;
        pops = 0; cyc = 0;
        while (pops < 3 && cyc < 30) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (out_valid && out_ready) pops++;
            cyc++;
        end
        @(posedge clk);
        #2;
        checks++; if (pops != 3 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid_setup got pops %0d busy %b want 3 1", pops, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1 || read_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got ready %b re %b busy %b done %b want 1 0 0 0", cmd_ready, read_enable, busy, done); end
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rst_mid_out got valid %b last %b want 0 0", out_valid, out_last); end
        checks++; if (read_address !== 8'h00 || out_data !== 16'h0) begin errors++; $display("FAIL rst_mid_addr_data got %h %h want 00 0000", read_address, out_data); end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL rst_mid_no_done got done pulse want none"); end
        collect(8'h20, 2, 0, 8'h00, 0, 0);
        checks++; if (timed_out || got_q.size() != 2) begin errors++; $display("FAIL rst_after_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            checks++; if (got_q[i] !== mem[8'h20 + i] || last_q[i] !== (i == 1)) begin errors++; $display("FAIL rst_after_word%0d got %h want %h", i, got_q[i], mem[8'h20 + i]); end
        end
        checks++; if (done_k.size() != 1) begin errors++; $display("FAIL rst_after_done got %0d want 1", done_k.size()); end
    endtask

    task automatic test_random;
        logic [7:0] a, ea;
        int         l, mode;
        for (int it = 0; it < 7; it++) begin
            for (int j = 0; j < 256; j++) mem[j] = 16'($urandom);
            a    = 8'($urandom);
            l    = (it == 6) ? 300 : $urandom_range(1, 40);
            mode = $urandom_range(0, 2);
            collect(a, l, 0, 8'h00, 0, mode);
            checks++; if (timed_out || got_q.size() != l || rd_addr_q.size() != l) begin errors++; $display("FAIL rnd%0d_count got %0d words %0d issues want %0d", it, got_q.size(), rd_addr_q.size(), l); end
            for (int i = 0; i < got_q.size() && i < rd_addr_q.size() && i < l; i++) begin
                ea = a + 8'(i);
                checks++; if (got_q[i] !== mem[ea] || last_q[i] !== (i == l - 1) || rd_addr_q[i] !== ea) begin errors++; $display("FAIL rnd%0d_word%0d got %h last %b addr %h want %h %b %h", it, i, got_q[i], last_q[i], rd_addr_q[i], mem[ea], (i == l - 1), ea); end
            end
            checks++; if (credit_viol != 0 || hold_viol != 0 || done_k.size() != 1) begin errors++; $display("FAIL rnd%0d_flow got credit %0d hold %0d done %0d want 0 0 1", it, credit_viol, hold_viol, done_k.size()); end
        end
    endtask

    initial begin
        for (int j = 0; j < 256; j++) mem[j] = 16'(j * 3);
        test_reset();
        test_no_backpressure();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no completion want summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
